// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl: shared types and constants for the hazard sequencer.
// Optional counters are enabled with PIPE_HAZARD_PERF_EN.
package pipe_hazard_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

    localparam int REG_W_DEF = 5;

    // Register $zero never carries a real dependency.
    localparam int ZERO_REG = 0;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_flush;
        logic freeze;
    } hazard_ctl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl: pipeline-facing signal bundle of the hazard sequencer.
// Counter outputs exist only when PIPE_HAZARD_PERF_EN is defined.
interface pipe_hazard_ctrl_if
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
);
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_rt;
    logic             id_branch_taken;
    logic             id_jump;
    logic             id_mdu_start;
    logic             id_mdu_read;
    logic             mem_req;
    logic             dmem_ready;

    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_flush;
    logic freeze;
    logic mdu_busy;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    modport master (
        output id_rs, id_rt, id_uses_rt,
        output ex_mem_read, ex_rt,
        output id_branch_taken, id_jump,
        output id_mdu_start, id_mdu_read,
        output mem_req, dmem_ready,
        input  pc_write, ifid_write,
        input  ifid_flush, idex_flush,
        input  freeze, mdu_busy
`ifdef PIPE_HAZARD_PERF_EN
        , input stall_cycles, flush_count
`endif
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt,
        input  ex_mem_read, ex_rt,
        input  id_branch_taken, id_jump,
        input  id_mdu_start, id_mdu_read,
        input  mem_req, dmem_ready,
        output pc_write, ifid_write,
        output ifid_flush, idex_flush,
        output freeze, mdu_busy
`ifdef PIPE_HAZARD_PERF_EN
        , output stall_cycles, flush_count
`endif
    );

endinterface

// File: rtl/hazard_mdu_timer.sv
// hazard_mdu_timer: models the fixed-latency MDU as a busy countdown.
// Reset doubles as abort: an in-flight operation is dropped at once.
module hazard_mdu_timer
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MDU_CYCLES = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic mdu_busy
);

    mdu_state_e state_q;
    mdu_state_e state_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // State and countdown registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Load on an accepted start; count down every cycle while busy.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN: begin
                if (start) begin
                    cnt_d   = 8'(MDU_CYCLES - 1);
                    state_d = MDU_BUSY;
                end
            end
            MDU_BUSY: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
        endcase
    end

    assign mdu_busy = (state_q == MDU_BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Define PIPE_HAZARD_PERF_EN to add stall and flush counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MDU_CYCLES = 32,
    parameter int REG_W      = REG_W_DEF
) (
    input logic               clk,
    input logic               reset,
    pipe_hazard_ctrl_if.slave bus
);

    logic        mem_wait;
    logic        load_use;
    logic        mdu_haz;
    logic        ctrl;
    logic        mdu_busy;
    logic        mdu_accept;
    hazard_ctl_t ctl;

    assign mem_wait = bus.mem_req & ~bus.dmem_ready;
    assign ctrl     = bus.id_branch_taken | bus.id_jump;
    assign mdu_haz  = mdu_busy
                    & (bus.id_mdu_read | bus.id_mdu_start);
    assign load_use = bus.ex_mem_read
                    & (bus.ex_rt != REG_W'(ZERO_REG))
                    & ((bus.ex_rt == bus.id_rs)
                      | (bus.id_uses_rt
                        & (bus.ex_rt == bus.id_rt)));

    // A start only counts when ID actually advances.
    assign mdu_accept = bus.id_mdu_start & ~reset
                      & ~mem_wait & ~load_use & ~mdu_haz;

    hazard_mdu_timer #(
        .MDU_CYCLES(MDU_CYCLES)
    ) u_mdu_timer (
        .clk     (clk),
        .reset   (reset),
        .start   (mdu_accept),
        .mdu_busy(mdu_busy)
    );

    // Priority: memory wait, then stalls, then control flush.
    always_comb begin
        ctl            = '0;
        ctl.pc_write   = 1'b1;
        ctl.ifid_write = 1'b1;
        if (reset) begin
            ctl.pc_write = 1'b1;
        end else if (mem_wait) begin
            ctl.freeze     = 1'b1;
            ctl.pc_write   = 1'b0;
            ctl.ifid_write = 1'b0;
        end else if (load_use | mdu_haz) begin
            ctl.pc_write   = 1'b0;
            ctl.ifid_write = 1'b0;
            ctl.idex_flush = 1'b1;
        end else if (ctrl) begin
            ctl.ifid_flush = 1'b1;
        end
    end

    assign bus.pc_write   = ctl.pc_write;
    assign bus.ifid_write = ctl.ifid_write;
    assign bus.ifid_flush = ctl.ifid_flush;
    assign bus.idex_flush = ctl.idex_flush;
    assign bus.freeze     = ctl.freeze;
    assign bus.mdu_busy   = mdu_busy;

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    // Free-running wrap-around event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!ctl.pc_write) begin
                stall_q <= stall_q + 32'd1;
            end
            if (ctl.ifid_flush) begin
                flush_q <= flush_q + 32'd1;
            end
        end
    end

    assign bus.stall_cycles = stall_q;
    assign bus.flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and randomized checks of the sequencer.
// Covers the counters too when PIPE_HAZARD_PERF_EN is defined.
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    localparam int MC = 4;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   busy_end = -1;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_m = '0;
    logic [31:0] flush_m = '0;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_W(5)) bus ();

    pipe_hazard_ctrl #(
        .MDU_CYCLES(MC),
        .REG_W     (5)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       u;
        logic       mr;
        logic [4:0] ert;
        logic       br;
        logic       jp;
        logic       ms;
        logic       md;
        logic       mq;
        logic       rdy;
        logic       rst;
    } stim_t;

    function automatic stim_t mk(
        int rs, int rt, bit u, bit mr, int ert,
        bit br, bit jp, bit ms, bit md,
        bit mq, bit rdy, bit rst);
        stim_t s;
        s.rs = 5'(rs);
        s.rt = 5'(rt);
        s.u = u;
        s.mr = mr;
        s.ert = 5'(ert);
        s.br = br;
        s.jp = jp;
        s.ms = ms;
        s.md = md;
        s.mq = mq;
        s.rdy = rdy;
        s.rst = rst;
        return s;
    endfunction

    function automatic stim_t idle();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    endfunction

    task automatic apply(input stim_t s);
        bus.id_rs = s.rs;
        bus.id_rt = s.rt;
        bus.id_uses_rt = s.u;
        bus.ex_mem_read = s.mr;
        bus.ex_rt = s.ert;
        bus.id_branch_taken = s.br;
        bus.id_jump = s.jp;
        bus.id_mdu_start = s.ms;
        bus.id_mdu_read = s.md;
        bus.mem_req = s.mq;
        bus.dmem_ready = s.rdy;
        reset = s.rst;
    endtask

    function automatic logic [5:0] observed();
        return {bus.pc_write, bus.ifid_write,
                bus.ifid_flush, bus.idex_flush,
                bus.freeze, bus.mdu_busy};
    endfunction

    // Reference: {pc_write, ifid_write, ifid_flush,
    // idex_flush, freeze, mdu_busy}, from the hazard rules.
    function automatic logic [5:0] model();
        bit busy;
        bit mw;
        bit lu;
        bit stall;
        busy = (cyc <= busy_end);
        mw = bus.mem_req && !bus.dmem_ready;
        lu = bus.ex_mem_read && (bus.ex_rt != 0)
            && (bus.ex_rt == bus.id_rs
                || (bus.id_uses_rt && bus.ex_rt == bus.id_rt));
        stall = lu || (busy
            && (bus.id_mdu_read || bus.id_mdu_start));
        if (reset) return {5'b11000, busy};
        if (mw) return {5'b00001, busy};
        if (stall) return {5'b00010, busy};
        if (bus.id_branch_taken || bus.id_jump)
            return {5'b11100, busy};
        return {5'b11000, busy};
    endfunction

    // Advance one clock; the model's MDU is a busy window.
    task automatic tick();
        logic [5:0] e;
        bit acc;
        e = model();
        acc = !reset && (cyc > busy_end)
            && bus.id_mdu_start && e[5];
`ifdef PIPE_HAZARD_PERF_EN
        if (reset) begin
            stall_m = '0;
            flush_m = '0;
        end else begin
            if (!e[5]) stall_m = stall_m + 1;
            if (e[3]) flush_m = flush_m + 1;
        end
`endif
        @(posedge clk);
        if (reset) busy_end = -1;
        else if (acc) busy_end = cyc + MC - 1;
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        apply(mk(8, 0, 0, 1, 8, 1, 0, 1, 0, 1, 0, 1));
        tick();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (observed() !== 6'b110000) begin
                errors++;
                $display("FAIL reset[%0d]: got %b expected %b",
                         i, observed(), 6'b110000);
            end
            tick();
        end
    endtask

    task automatic test_load_use();
        stim_t v[$];
        logic [5:0] x[$];
        v.push_back(mk(8, 0, 0, 1, 8, 0, 0, 0, 0, 0, 1, 0));
        x.push_back(6'b000100);
        v.push_back(idle());
        x.push_back(6'b110000);
        v.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        x.push_back(6'b110000);
        v.push_back(mk(3, 9, 0, 1, 9, 0, 0, 0, 0, 0, 1, 0));
        x.push_back(6'b110000);
        v.push_back(mk(3, 9, 1, 1, 9, 0, 0, 0, 0, 0, 1, 0));
        x.push_back(6'b000100);
        v.push_back(mk(1, 2, 1, 1, 7, 0, 0, 0, 0, 0, 1, 0));
        x.push_back(6'b110000);
        for (int i = 0; i < v.size(); i++) begin
            apply(v[i]);
            @(negedge clk);
            checks++;
            if (observed() !== x[i]) begin
                errors++;
                $display("FAIL load_use[%0d]: got %b expected %b",
                         i, observed(), x[i]);
            end
            tick();
        end
    endtask

    task automatic test_branch();
        stim_t v[$];
        logic [5:0] x[$];
        v.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        x.push_back(6'b111000);
        v.push_back(mk(8, 0, 0, 1, 8, 1, 0, 0, 0, 0, 1, 0));
        x.push_back(6'b000100);
        v.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        x.push_back(6'b111000);
        v.push_back(idle());
        x.push_back(6'b110000);
        for (int i = 0; i < v.size(); i++) begin
            apply(v[i]);
            @(negedge clk);
            checks++;
            if (observed() !== x[i]) begin
                errors++;
                $display("FAIL branch[%0d]: got %b expected %b",
                         i, observed(), x[i]);
            end
            tick();
        end
    endtask

    task automatic test_mdu();
        stim_t st, rd, rs, id;
        stim_t v[$];
        logic [5:0] x[$];
        st = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        rd = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        rs = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        id = idle();
        v = '{st, rd, rd, rd, rd, st, st, id, rs, id};
        x = '{6'b110000, 6'b000101, 6'b000101, 6'b000101,
              6'b110000, 6'b110000, 6'b000101, 6'b110001,
              6'b110001, 6'b110000};
        for (int i = 0; i < v.size(); i++) begin
            apply(v[i]);
            @(negedge clk);
            checks++;
            if (observed() !== x[i]) begin
                errors++;
                $display("FAIL mdu[%0d]: got %b expected %b",
                         i, observed(), x[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        stim_t st, br, id;
        stim_t v[$];
        logic [5:0] x[$];
        st = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        br = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        id = idle();
        v = '{st, st, st, st, st, id, br, id, id};
        x = '{6'b110000, 6'b000101, 6'b000101, 6'b000101,
              6'b110000, 6'b110001, 6'b111001, 6'b110001,
              6'b110000};
        for (int i = 0; i < v.size(); i++) begin
            apply(v[i]);
            @(negedge clk);
            checks++;
            if (observed() !== x[i]) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %b expected %b",
                         i, observed(), x[i]);
            end
            tick();
        end
    endtask

    task automatic test_mem_wait();
        stim_t st, mw, ok, sw, id;
        stim_t v[$];
        logic [5:0] x[$];
        st = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        mw = mk(8, 0, 0, 1, 8, 0, 1, 0, 0, 1, 0, 0);
        ok = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        sw = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        id = idle();
        v = '{st, mw, mw, mw, ok, sw, id, id};
        x = '{6'b110000, 6'b000011, 6'b000011, 6'b000011,
              6'b110000, 6'b000010, 6'b110000, 6'b110000};
        for (int i = 0; i < v.size(); i++) begin
            apply(v[i]);
            @(negedge clk);
            checks++;
            if (observed() !== x[i]) begin
                errors++;
                $display("FAIL mem_wait[%0d]: got %b expected %b",
                         i, observed(), x[i]);
            end
            tick();
        end
    endtask

`ifdef PIPE_HAZARD_PERF_EN
    task automatic test_perf();
        stim_t rs, lu, br, mw, bo;
        stim_t v[$];
        rs = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        lu = mk(8, 0, 0, 1, 8, 0, 0, 0, 0, 0, 1, 0);
        br = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        mw = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
        bo = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0);
        v = '{rs, lu, br, mw, mw, mw, bo};
        for (int i = 0; i < v.size(); i++) begin
            apply(v[i]);
            tick();
        end
        apply(idle());
        @(negedge clk);
        checks++;
        if (bus.stall_cycles !== 32'd4) begin
            errors++;
            $display("FAIL perf_stall: got %0d expected 4",
                     bus.stall_cycles);
        end
        checks++;
        if (bus.flush_count !== 32'd2) begin
            errors++;
            $display("FAIL perf_flush: got %0d expected 2",
                     bus.flush_count);
        end
        force dut.stall_q = 32'hFFFF_FFFF;
        force dut.flush_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_q;
        release dut.flush_q;
        stall_m = 32'hFFFF_FFFF;
        flush_m = 32'hFFFF_FFFF;
        apply(lu);
        tick();
        apply(br);
        tick();
        apply(idle());
        @(negedge clk);
        checks++;
        if (bus.stall_cycles !== 32'd0
            || bus.flush_count !== 32'd0) begin
            errors++;
            $display("FAIL perf_wrap: got %h/%h expected 0/0",
                     bus.stall_cycles, bus.flush_count);
        end
    endtask
`endif

    task automatic test_random();
        stim_t s;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        tick();
        for (int i = 0; i < 400; i++) begin
            s.rs = 5'($urandom_range(0, 3));
            s.rt = 5'($urandom_range(0, 3));
            s.u = 1'($urandom_range(0, 1));
            s.mr = 1'($urandom_range(0, 1));
            s.ert = 5'($urandom_range(0, 3));
            s.br = ($urandom_range(0, 4) == 0);
            s.jp = ($urandom_range(0, 5) == 0);
            s.ms = ($urandom_range(0, 3) == 0);
            s.md = ($urandom_range(0, 3) == 0);
            s.mq = ($urandom_range(0, 2) == 0);
            s.rdy = 1'($urandom_range(0, 1));
            s.rst = ($urandom_range(0, 40) == 0);
            apply(s);
            @(negedge clk);
            checks++;
            if (observed() !== model()) begin
                errors++;
                $display("FAIL random[%0d]: got %b expected %b",
                         i, observed(), model());
            end
`ifdef PIPE_HAZARD_PERF_EN
            checks++;
            if (bus.stall_cycles !== stall_m
                || bus.flush_count !== flush_m) begin
                errors++;
                $display("FAIL random_perf[%0d]: got %0d/%0d expected %0d/%0d",
                         i, bus.stall_cycles, bus.flush_count,
                         stall_m, flush_m);
            end
`endif
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mdu();
        test_back_to_back();
        test_mem_wait();
`ifdef PIPE_HAZARD_PERF_EN
        test_perf();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
